// File: rtl/mem_lsu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_lsu: load/store unit driving dataMemory; sub-word loads are        |
// | extracted/extended, sub-word stores use read-modify-write.             |
// | Optional macro MEM_LSU_PERF_EN adds saturating perf counters.          |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module mem_lsu #(
  parameter int MEM_RD_LAT = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_active,
  output logic              mem_rw,
  output logic [31:0]       mem_index,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [4:0]        resp_rd,
`ifdef MEM_LSU_PERF_EN
  output logic [31:0]       perf_loads,
  output logic [31:0]       perf_stores,
  output logic [31:0]       perf_faults,
`endif
  output logic              resp_fault
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int              CNT_W       = 2;
  localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(MEM_RD_LAT - 1);

  state_t           state_q;
  logic             we_q, sign_q;
  logic [1:0]       size_q, lane_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_active_q, mem_rw_q;
  logic [31:0]      mem_index_q, mem_wdata_q, resp_data_q;
  logic [4:0]       resp_rd_q;
  logic             resp_valid_q, resp_fault_q;

  logic             fault_d;
  logic [31:0]      index_d, shifted_d, load_d, mask_d, merge_d;

  assign fault_d = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign index_d = 32'(req_addr[ADDR_W-1:2]);

  // Halves are always half-aligned here, so lane*8 equals addr[1]*16.
  assign shifted_d = mem_rdata >> {lane_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_d = {{24{sign_q & shifted_d[7]}}, shifted_d[7:0]};
      2'b01:   load_d = {{16{sign_q & shifted_d[15]}}, shifted_d[15:0]};
      default: load_d = mem_rdata;
    endcase
  end

  always_comb begin
    mask_d  = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
    mask_d  = mask_d << {lane_q, 3'b000};
    merge_d = (mem_rdata & ~mask_d) | ((wdata_q << {lane_q, 3'b000}) & mask_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      sign_q       <= 1'b0;
      size_q       <= 2'b00;
      lane_q       <= 2'b00;
      wdata_q      <= '0;
      cnt_q        <= '0;
      mem_active_q <= 1'b0;
      mem_rw_q     <= 1'b0;
      mem_index_q  <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            sign_q    <= req_sign;
            size_q    <= req_size;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata;
            resp_rd_q <= req_rd;
            cnt_q     <= RD_CNT_INIT;
            if (fault_d) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_data_q  <= '0;
            end else begin
              mem_active_q <= 1'b1;
              mem_index_q  <= index_d;
              if (req_we && req_size == 2'b10) begin
                state_q     <= ST_WR;
                mem_rw_q    <= 1'b1;
                mem_wdata_q <= req_wdata;
              end else begin
                state_q  <= ST_RD;
                mem_rw_q <= 1'b0;
              end
            end
          end
        end
        ST_RD: begin
          if (cnt_q == '0) begin
            if (we_q) begin
              state_q     <= ST_WR;
              mem_rw_q    <= 1'b1;
              mem_wdata_q <= merge_d;
            end else begin
              state_q      <= ST_RESP;
              mem_active_q <= 1'b0;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b0;
              resp_data_q  <= load_d;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ST_WR: begin
          state_q      <= ST_RESP;
          mem_active_q <= 1'b0;
          mem_rw_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_fault_q <= 1'b0;
          resp_data_q  <= '0;
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign mem_active = mem_active_q;
  assign mem_rw     = mem_rw_q;
  assign mem_index  = mem_index_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign resp_fault = resp_fault_q;

`ifdef MEM_LSU_PERF_EN
  logic [31:0] perf_loads_q, perf_stores_q, perf_faults_q;
  logic        hs_d;

  assign hs_d = (state_q == ST_RESP) && resp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_loads_q  <= '0;
      perf_stores_q <= '0;
      perf_faults_q <= '0;
    end else if (hs_d) begin
      if (resp_fault_q) begin
        if (perf_faults_q != 32'hFFFF_FFFF) perf_faults_q <= perf_faults_q + 32'd1;
      end else if (we_q) begin
        if (perf_stores_q != 32'hFFFF_FFFF) perf_stores_q <= perf_stores_q + 32'd1;
      end else begin
        if (perf_loads_q != 32'hFFFF_FFFF) perf_loads_q <= perf_loads_q + 32'd1;
      end
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
  assign perf_faults = perf_faults_q;
`else
  // Default build carries no performance counters.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mem_lsu: directed plus random load/store traffic against a byte-    |
// | array reference model and a simple word memory.                        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_mem_lsu;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, req_we, req_sign;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [4:0]  req_rd;
  logic        mem_active, mem_rw;
  logic [31:0] mem_index, mem_wdata, mem_rdata;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;

  always #5 clk = ~clk;

  mem_lsu #(.MEM_RD_LAT(LAT), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_sign(req_sign),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_active(mem_active), .mem_rw(mem_rw), .mem_index(mem_index),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_fault(resp_fault)
  );

  // Word memory standing in for dataMemory: combinational read, write mid-cycle.
  logic [31:0] tb_mem [16] = '{default: '0};
  assign mem_rdata = tb_mem[mem_index[3:0]];

  int          act_cyc = 0, wr_cyc = 0, idx_err = 0;
  logic        prev_act = 1'b0;
  logic [31:0] prev_idx = '0, last_act_idx = '0, last_wdata = '0;

  always @(negedge clk) begin
    if (mem_active) begin
      act_cyc++;
      last_act_idx = mem_index;
      if (prev_act && mem_index !== prev_idx) idx_err++;
      if (mem_rw) begin
        wr_cyc++;
        tb_mem[mem_index[3:0]] = mem_wdata;
        last_wdata = mem_wdata;
      end
    end
    prev_act = mem_active;
    prev_idx = mem_index;
  end

  logic [7:0] ref_mem [64];
  int n_pass = 0, n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_op(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic sign, input logic [31:0] wdata, input logic [4:0] rd,
                       input int stall);
    int nb, ai, wa, exp_lat, exp_act, exp_wr, a0, w0, e0, cyc;
    bit fault;
    logic [31:0] v, exp_data, exp_word;
    ai = int'(addr[5:0]);
    wa = ai & ~3;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    fault = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
    exp_data = '0;
    exp_word = '0;
    if (fault) begin
      exp_lat = 1; exp_act = 0; exp_wr = 0;
    end else if (we) begin
      for (int b = 0; b < nb; b++) ref_mem[ai + b] = wdata[8*b +: 8];
      exp_word = {ref_mem[wa + 3], ref_mem[wa + 2], ref_mem[wa + 1], ref_mem[wa]};
      exp_lat = (size == 2'd2) ? 2 : 2 + LAT;
      exp_act = (size == 2'd2) ? 1 : 1 + LAT;
      exp_wr  = 1;
    end else begin
      v = '0;
      for (int b = 0; b < nb; b++) v = v | (32'(ref_mem[ai + b]) << (8 * b));
      if (sign && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      exp_data = v;
      exp_lat = 1 + LAT; exp_act = LAT; exp_wr = 0;
    end

    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_sign = sign; req_wdata = wdata; req_rd = rd;
    resp_ready = (stall == 0);
    a0 = act_cyc; w0 = wr_cyc; e0 = idx_err;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = $urandom;
    req_size = 2'($urandom); req_sign = $urandom_range(0, 1);
    req_wdata = $urandom; req_rd = 5'($urandom);

    cyc = 0;
    while (cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) break;
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    check("resp_data", resp_data, exp_data);
    check("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
    check("resp_fault", {31'd0, resp_fault}, {31'd0, fault});
    check("mem_active_cycles", 32'(act_cyc - a0), 32'(exp_act));
    check("write_cycles", 32'(wr_cyc - w0), 32'(exp_wr));
    check("index_stable", 32'(idx_err - e0), 32'd0);
    if (exp_act > 0) check("mem_index", last_act_idx, addr >> 2);
    if (exp_wr > 0)  check("mem_wdata", last_wdata, exp_word);

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, resp_valid}, 32'd1);
      check("stall_data", resp_data, exp_data);
      check("stall_fault", {31'd0, resp_fault}, {31'd0, fault});
      check("stall_mem_idle", {31'd0, mem_active}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("resp_done", {31'd0, resp_valid}, 32'd0);
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'd0;
    req_sign = 1'b0; req_wdata = '0; req_rd = '0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mem_active", {31'd0, mem_active}, 32'd0);
    check("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
    check("rst_mem_index", mem_index, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_rd", {27'd0, resp_rd}, 32'd0);
    rst_n = 1'b1;

    do_op(1'b1, 32'h4, 2'd2, 1'b0, 32'h8899AABB, 5'd3, 0);
    do_op(1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 5'd4, 0);
    do_op(1'b0, 32'h5, 2'd0, 1'b1, 32'h0, 5'd5, 0);
    do_op(1'b0, 32'h5, 2'd0, 1'b0, 32'h0, 5'd6, 0);
    do_op(1'b0, 32'h6, 2'd1, 1'b1, 32'h0, 5'd7, 0);
    do_op(1'b1, 32'h7, 2'd0, 1'b0, 32'hDEADBE11, 5'd8, 0);
    do_op(1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 5'd9, 0);
    do_op(1'b0, 32'h6, 2'd2, 1'b0, 32'h0, 5'd10, 0);
    do_op(1'b1, 32'h8, 2'd3, 1'b0, 32'h12345678, 5'd11, 0);
    do_op(1'b1, 32'h2, 2'd1, 1'b0, 32'hFFFFC0DE, 5'd12, 5);
    do_op(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 5'd13, 5);

    // Reset while a byte store sits in its read phase: the write must never happen.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h9; req_size = 2'd0;
    req_wdata = 32'h000000EE; req_rd = 5'd14;
    w0 = wr_cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rmw_in_read", {30'd0, mem_active, mem_rw}, 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_mem_active", {31'd0, mem_active}, 32'd0);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_no_write", 32'(wr_cyc - w0), 32'd0);
    check("abort_no_resp", {31'd0, resp_valid}, 32'd0);
    do_op(1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 5'd15, 0);

    for (int n = 0; n < 40; n++) begin
      do_op(1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)), 2'($urandom),
            1'($urandom_range(0, 1)), $urandom, 5'($urandom),
            ($urandom_range(0, 7) == 0) ? 3 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store unit sitting directly upstream of dataMemory in the processor's MEM stage.
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Drives dataMemory's active/rw/index/input port and captures its output port.
- Performs sub-word (byte/half) access: loads are extracted and extended; stores use read-modify-write. Returns a result tagged with the destination register.

Parameters:
- MEM_RD_LAT, 1, cycles mem_active is held for a read before mem_rdata is sampled (1..4).
- ADDR_W, 32, byte address width; mem_index = addr[ADDR_W-1:2] zero-extended to 32 bits.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  LSU can accept (high only in IDLE)
- req_we  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_sign  in  1  loads: 1=sign-extend, 0=zero-extend
- req_wdata  in  32  store data, right-aligned
- req_rd  in  5  destination register tag
- mem_active  out  1  to dataMemory active
- mem_rw  out  1  to dataMemory rw: 1=write, 0=read
- mem_index  out  32  word index
- mem_wdata  out  32  to dataMemory input
- mem_rdata  in  32  from dataMemory output
- resp_valid  out  1  result present
- resp_ready  in  1  consumer accepts result
- resp_data  out  32  load result (0 for stores/faults)
- resp_rd  out  5  tag copied from request
- resp_fault  out  1  misaligned or illegal-size request

Behaviour:
- Reset: with rst_n low at a rising edge, next state is IDLE. req_ready=1; mem_active, mem_rw, resp_valid and resp_fault=0; mem_index, mem_wdata, resp_data and resp_rd=0.
- Reset mid-operation aborts the operation. mem_active drops on the next edge. No write is issued after reset, and any pending response is discarded.
- Request latching: the request is accepted on an edge where req_valid & req_ready, and all request fields are latched at that edge.
- Lane selection: little-endian; lane = addr[1:0]. A byte uses lane*8. A half uses addr[1]*16.
- Fault rule:
  - A fault is size=11, a half with addr[0]=1, or a word with addr[1:0]!=0.
  - Faulting requests generate no memory access: IDLE -> RESP with resp_fault=1 and resp_data=0.
- FSM states: IDLE, RD, WR, RESP.
  - IDLE -> RD: accepted load, or accepted sub-word store.
  - IDLE -> WR: accepted word store.
  - IDLE -> RESP: accepted faulting request.
  - RD:
    - mem_active=1, mem_rw=0 for MEM_RD_LAT cycles, tracked by a down-counter.
    - mem_rdata is captured on the edge ending the last RD cycle.
    - Load: extract lane, extend per req_sign, go to RESP.
    - Sub-word store: merge req_wdata's low byte/half into the captured word at the lane, go to WR.
  - WR: one cycle, mem_active=1, mem_rw=1, mem_wdata = full or merged word, then -> RESP.
  - RESP: resp_valid=1, holding resp_data/resp_rd/resp_fault stable until resp_ready. -> IDLE on the edge where resp_ready=1.
- Memory outputs:
  - mem_active=0 in IDLE and RESP.
  - mem_index is held constant through RD and WR of one operation.
- Latency (accept edge = edge 0), assuming resp_ready is high:
  - Word store: resp_valid in cycle 2.
  - Load: resp_valid in cycle 1+MEM_RD_LAT.
  - Sub-word store: resp_valid in cycle 2+MEM_RD_LAT.
  - Fault: resp_valid in cycle 1.
- Back-to-back: a new request is accepted no earlier than the edge after the RESP handshake, i.e. there is one IDLE cycle between operations.
- Stalls: req_valid may drop without a handshake. resp_ready low stalls indefinitely in RESP with no memory activity.

Optional Feature:
- Macro: MEM_LSU_PERF_EN.
- Defined: adds outputs perf_loads, perf_stores and perf_faults (32 bits each).
  - Cleared by reset.
  - Each increments on the RESP handshake edge of a successful load, a successful store, or a faulting request respectively.
  - Counters saturate at 0xFFFFFFFF.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Word store then load: store addr 0x4, wdata 0x8899AABB -> one WR cycle with mem_index=1, mem_wdata=0x8899AABB, resp at cycle 2. Load word at 0x4 -> resp_data=0x8899AABB at cycle 2 (MEM_RD_LAT=1).
- Signed/unsigned byte load: word 1 = 0x8899AABB. Load byte at 0x5 with sign=1 -> 0xFFFFFFAA. With sign=0 -> 0x000000AA. Signed half load at 0x6 -> 0xFFFF8899.
- Sub-word store RMW: word 1 = 0x8899AABB. Store byte 0x11 at 0x7 -> RD then WR, mem_wdata=0x1199AABB, resp at cycle 3.
- Misaligned: word load at 0x6 -> no mem_active pulse, resp_fault=1, resp_data=0 at cycle 1. Size=11 gives the same result.
- Backpressure/reset: hold resp_ready=0 for 5 cycles -> resp fields stable and mem_active=0. Then assert rst_n=0 during RD of a byte store -> no WR cycle occurs and req_ready=1 after the reset edge.
